prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream boot stage for the processor core.
- Receives a byte stream over a valid/ready handshake and assembles 32-bit instruction words little-endian.
- Writes the words sequentially into instruction memory starting at word address 0.
- Holds the core in reset until the whole program is loaded, then releases it.

Parameters:
- ADDR_W, 10, instruction memory word-address width; depth = 2^ADDR_W words.
- TIMEOUT, 65535, max idle cycles allowed between bytes once a frame has started.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid & in_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  word to write.
- cpu_rst  output  1  reset to the core; high until load completes.
- done  output  1  load completed successfully (sticky).
- err  output  1  frame error (sticky).

Behaviour:
- Reset (RST high, asynchronous): state=LEN_LO, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0. Byte counter, word counter and timeout counter cleared.
- First cycle after RST falls: in_ready=1.
- Frame format: 16-bit word count N (LSB first), then 4N data bytes. Each word's bytes arrive LSB first: byte0→[7:0], byte1→[15:8], byte2→[23:16], byte3→[31:24].
- States:
  - LEN_LO: on transfer, latch N[7:0] → LEN_HI.
  - LEN_HI: on transfer, latch N[15:8], then check N. If N==0 or N>2^ADDR_W → ERR; else → DATA.
  - DATA: accept bytes into a 32-bit shift/assemble register with a 2-bit byte index. On the 4th byte transfer → WRITE.
  - WRITE: one cycle. mem_we=1, mem_wdata=assembled word, mem_addr=current word index, in_ready=0. The next cycle increments word index; mem_we returns to 0.
    - If the written word was word N-1 → DONE.
    - Otherwise → DATA.
  - DONE: cpu_rst=0 and done=1 from the cycle after the final WRITE. in_ready=0; further bytes are ignored until RST.
  - ERR: err=1, cpu_rst stays 1, in_ready=0; stays here until RST.
- Latency: final mem_we occurs the cycle after the 4th byte of word N-1 is accepted; cpu_rst falls one cycle after that.
- mem_addr holds its last value when not writing. mem_wdata holds the last written word.
- Timeout:
  - The counter runs only in LEN_HI and DATA (frame started).
  - It resets on every transfer.
  - On reaching TIMEOUT with no transfer → ERR.
  - It does not run in LEN_LO, so waiting for the first byte is unlimited.
- in_valid with in_ready=0 (WRITE, DONE, ERR): no byte consumed, no state change.
- N==2^ADDR_W: the last write goes to address 2^ADDR_W-1; the word index must not wrap before DONE.
- RST mid-load: immediate return to reset values. Memory contents already written are left as-is; a fresh frame restarts at address 0.

Test Plan:
- N=2, bytes 02 00 | 13 00 00 00 | 37 21 43 65, in_valid held high → mem_we pulses at addr 0 data 0x00000013 and addr 1 data 0x65432137. cpu_rst falls the cycle after the second write; done=1, err=0.
- Same frame with in_valid toggled every other cycle → identical writes and data; no byte is lost or duplicated during the WRITE cycles where in_ready=0.
- N=0 (bytes 00 00) → err=1 after the second byte; no mem_we ever; cpu_rst remains 1.
- ADDR_W=4 with N=17 → err=1; N=16 with 64 bytes → last write at addr 15, then done=1.
- TIMEOUT=8: send N=1 plus 2 data bytes, then idle 8 cycles → err=1, cpu_rst=1, no mem_we.
- Assert RST after 5 data bytes of N=2, then send a full N=1 frame → all outputs return to reset values while RST is high; the new word is written at addr 0 and done=1.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs little-endian 32-bit
// words into instruction memory from address 0, then releases the core reset.
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

  localparam int          TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          bidx_q, bidx_d;
  // One extra bit so a full-depth load never wraps before the last compare.
  logic [ADDR_W:0]     word_q, word_d, word_nxt;
  logic [31:0]         asm_q, asm_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic        xfer, tmo_hit;
  logic [15:0] len_new;

  assign xfer     = in_valid & in_ready_q;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
  assign len_new  = {in_data, len_q[7:0]};
  assign word_nxt = word_q + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    asm_d       = asm_q;
    tmo_d       = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Idle counter only matters once the frame has started.
    if (state_q == S_LEN_HI || state_q == S_DATA)
      tmo_d = xfer ? '0 : tmo_q + TW'(1);

    case (state_q)
      S_LEN_LO: if (xfer) begin
        len_d[7:0] = in_data;
        state_d    = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          if (len_new == 16'd0 || {1'b0, len_new} > DEPTH) state_d = S_ERR;
          else                                               state_d = S_DATA;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d  = {in_data, asm_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = word_q[ADDR_W-1:0];
            mem_wdata_d = {in_data, asm_q[31:8]};
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        word_d  = word_nxt;
        state_d = (17'(word_nxt) == {1'b0, len_q}) ? S_DONE : S_DATA;
      end
      default: ;
    endcase

    in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
    cpu_rst_d  = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_LEN_LO;
      len_q       <= '0;
      bidx_q      <= '0;
      word_q      <= '0;
      asm_q       <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      asm_q       <= asm_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (ADDR_W=4, TIMEOUT=8): normal load, gapped
// stream, length errors, full-depth load, idle timeout and mid-load reset.
module tb_prog_loader;
  localparam int AW = 4;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, cpu_rst, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  prog_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int last_xfer = 0;
  int rst_fall_cyc = -1;
  logic cpu_rst_prev = 1'b1;
  logic [31:0]   wdata_log[$];
  logic [AW-1:0] waddr_log[$];
  int            wcyc_log[$];

  always @(negedge CLK) begin
    if (mem_we) begin
      wdata_log.push_back(mem_wdata);
      waddr_log.push_back(mem_addr);
      wcyc_log.push_back(cyc);
    end
    if (cpu_rst_prev && !cpu_rst) rst_fall_cyc = cyc;
    cpu_rst_prev = cpu_rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL send_stall: observed in_ready=0 expected in_ready=1 for byte %0h", b);
    end
    last_xfer = cyc + 1;
    @(negedge CLK);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    wdata_log.delete();
    waddr_log.delete();
    wcyc_log.delete();
    rst_fall_cyc = -1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_cpu_rst"},   32'(cpu_rst),   32'd1);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  task automatic run_frame2(input bit gap, input string tag);
    logic [7:0] fr [10];
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h21, 8'h43, 8'h65};
    for (int i = 0; i < 10; i++) send(fr[i], gap);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk({tag, "_nwrites"}, 32'(wdata_log.size()), 32'd2);
    if (wdata_log.size() == 2) begin
      chk({tag, "_addr0"}, 32'(waddr_log[0]), 32'd0);
      chk({tag, "_data0"}, wdata_log[0], 32'h0000_0013);
      chk({tag, "_addr1"}, 32'(waddr_log[1]), 32'd1);
      chk({tag, "_data1"}, wdata_log[1], 32'h6543_2137);
      chk({tag, "_we_lat"}, 32'(wcyc_log[1]), 32'(last_xfer));
      chk({tag, "_rst_lat"}, 32'(rst_fall_cyc), 32'(wcyc_log[1] + 1));
    end
    chk({tag, "_done"},    32'(done),     32'd1);
    chk({tag, "_err"},     32'(err),      32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst),  32'd0);
    chk({tag, "_ready"},   32'(in_ready), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    repeat (20) @(negedge CLK);
    chk("lenlo_no_timeout_err", 32'(err), 32'd0);
    chk("lenlo_no_timeout_rdy", 32'(in_ready), 32'd1);

    // Back-to-back bytes, then bytes offered after DONE must be ignored.
    run_frame2(1'b0, "held");
    in_data = 8'hFF;
    in_valid = 1'b1;
    repeat (4) @(negedge CLK);
    in_valid = 1'b0;
    chk("done_ignore_writes", 32'(wdata_log.size()), 32'd2);
    chk("done_sticky", 32'(done), 32'd1);

    reset_dut();
    run_frame2(1'b1, "gapped");

    reset_dut();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("n0_err",     32'(err),     32'd1);
    chk("n0_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("n0_done",    32'(done),    32'd0);
    chk("n0_ready",   32'(in_ready), 32'd0);
    chk("n0_nwrites", 32'(wdata_log.size()), 32'd0);

    reset_dut();
    send(8'h11, 1'b0);
    send(8'h00, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("n17_err",     32'(err), 32'd1);
    chk("n17_nwrites", 32'(wdata_log.size()), 32'd0);

    reset_dut();
    send(8'h10, 1'b0);
    send(8'h00, 1'b0);
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 4; b++) send(8'(w * 4 + b), 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("n16_nwrites", 32'(wdata_log.size()), 32'd16);
    if (wdata_log.size() == 16) begin
      for (int w = 0; w < 16; w++) begin
        chk($sformatf("n16_addr%0d", w), 32'(waddr_log[w]), 32'(w));
        chk($sformatf("n16_data%0d", w), wdata_log[w],
            {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)});
      end
    end
    chk("n16_done",    32'(done),    32'd1);
    chk("n16_cpu_rst", 32'(cpu_rst), 32'd0);

    // Last byte accepted at edge E; the eighth idle edge is E+8.
    reset_dut();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    in_valid = 1'b0;
    repeat (7) @(negedge CLK);
    chk("tmo_err_before", 32'(err), 32'd0);
    @(negedge CLK);
    chk("tmo_err",     32'(err),     32'd1);
    chk("tmo_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("tmo_ready",   32'(in_ready), 32'd0);
    chk("tmo_nwrites", 32'(wdata_log.size()), 32'd0);

    reset_dut();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    in_valid = 1'b0;
    chk("midrst_pre_nwrites", 32'(wdata_log.size()), 32'd1);
    RST = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge CLK);
    wdata_log.delete();
    waddr_log.delete();
    wcyc_log.delete();
    RST = 1'b0;
    @(negedge CLK);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("restart_nwrites", 32'(wdata_log.size()), 32'd1);
    if (wdata_log.size() == 1) begin
      chk("restart_addr", 32'(waddr_log[0]), 32'd0);
      chk("restart_data", wdata_log[0], 32'hDDCC_BBAA);
    end
    chk("restart_done",    32'(done),    32'd1);
    chk("restart_cpu_rst", 32'(cpu_rst), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
